// File: rtl/wrapper_feeder.sv
// Byte-pair packer feeding the write side of the dual-clock word buffer.
// Ports: clk_1/rst, in_valid/in_byte/in_ready byte stream, flush,
//   buffer_full/buffer_empty (async), data_1/data_1_en word write,
//   burst_done, busy, word_cnt.
module wrapper_feeder #(
  parameter int          BURST_LEN = 7,
  parameter logic [7:0]  PAD_BYTE  = 8'h00
) (
  input  logic        clk_1,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  input  logic        flush,
  input  logic        buffer_full,
  input  logic        buffer_empty,
  output logic [15:0] data_1,
  output logic        data_1_en,
  output logic        burst_done,
  output logic        busy,
  output logic [2:0]  word_cnt
);

  localparam logic [1:0] FILL_LO    = 2'd0;
  localparam logic [1:0] FILL_HI    = 2'd1;
  localparam logic [1:0] PUSH       = 2'd2;
  localparam logic [1:0] WAIT_DRAIN = 2'd3;

  localparam logic [2:0] LAST = 3'(BURST_LEN - 1);

  logic [1:0] state;
  logic [7:0] lo;
  logic       ending;
  logic       flush_pend;
  logic       full_m;
  logic       full_s;
  logic       empty_m;
  logic       empty_s;

  logic accept;
  logic push;
  logic last;
  logic early;
  logic hi_flush;

  assign in_ready  = (state == FILL_LO) || (state == FILL_HI);
  assign accept    = in_valid && in_ready;
  assign push      = (state == PUSH) && !full_s;
  assign last      = ending || (word_cnt == LAST);
  // flush with nothing half-packed closes a non-empty burst right away
  assign early     = (state == FILL_LO) && flush && !accept
                     && (word_cnt != 3'd0);
  // a flush that arrived with the low byte is carried into FILL_HI
  assign hi_flush  = flush || flush_pend;
  assign data_1_en = push;
  assign burst_done = (push && last) || early;
  assign busy      = !((state == FILL_LO) && (word_cnt == 3'd0));

  always_ff @(posedge clk_1) begin
    if (rst) begin
      full_m  <= 1'b0;
      full_s  <= 1'b0;
      empty_m <= 1'b1;
      empty_s <= 1'b1;
    end else begin
      full_m  <= buffer_full;
      full_s  <= full_m;
      empty_m <= buffer_empty;
      empty_s <= empty_m;
    end
  end

  always_ff @(posedge clk_1) begin
    if (rst) begin
      state      <= FILL_LO;
      lo         <= 8'h00;
      data_1     <= 16'h0000;
      word_cnt   <= 3'd0;
      ending     <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      unique case (state)
        FILL_LO: begin
          if (accept) begin
            lo         <= in_byte;
            flush_pend <= flush;
            state      <= FILL_HI;
          end else if (early) begin
            word_cnt <= 3'd0;
            state    <= WAIT_DRAIN;
          end
        end
        FILL_HI: begin
          if (accept) begin
            data_1     <= {in_byte, lo};
            ending     <= hi_flush;
            flush_pend <= 1'b0;
            state      <= PUSH;
          end else if (hi_flush) begin
            data_1     <= {PAD_BYTE, lo};
            ending     <= 1'b1;
            flush_pend <= 1'b0;
            state      <= PUSH;
          end
        end
        PUSH: begin
          // full_s high: hold the word, retry next cycle
          if (!full_s) begin
            if (last) begin
              word_cnt <= 3'd0;
              ending   <= 1'b0;
              state    <= WAIT_DRAIN;
            end else begin
              word_cnt <= word_cnt + 3'd1;
              state    <= FILL_LO;
            end
          end
        end
        WAIT_DRAIN: begin
          // buffer rewinds only after a full drain
          if (empty_s && !full_s) state <= FILL_LO;
        end
        default: state <= FILL_LO;
      endcase
    end
  end

endmodule
